rgmii_rx_framer: RTL and testbench

//  Next-generation RGMII receive stage. Takes the per-edge DDR samples of RX_CTL/RXD from the IDDR

---
 rtl/rgmii_rx_framer_if.sv | 14 +
 rtl/rgmii_rx_framer.sv | 205 ++++++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_rx_framer_if.sv
// Framed receive byte stream leaving the RGMII framer towards the MAC/parser.
interface rgmii_rx_framer_if #(
  parameter int LEN_W = 11
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sop;
  logic             rx_eop;
  logic             rx_err;
  logic [LEN_W-1:0] rx_len;

  modport master (output rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_len);
  modport slave  (input  rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_len);
endinterface

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: rebuilds bytes from the IDDR samples (1G DDR bytes or
// 10/100 nibbles), strips preamble/SFD and emits a framed byte stream with
// sop/eop/err, the frame length and good/bad frame counters.
module rgmii_rx_framer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MAX_PREAMBLE  = 7,
  parameter int LEN_W         = 11,
  parameter int CNT_W         = 16
) (
  input  logic              gmii_rx_clk,
  input  logic              rst_n,
  input  logic              speed_1g,
  input  logic              ddr_ctl_p,
  input  logic              ddr_ctl_n,
  input  logic [3:0]        ddr_d_p,
  input  logic [3:0]        ddr_d_n,
  rgmii_rx_framer_if.master rx,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt
);

  localparam int PRE_W = $clog2(MAX_PREAMBLE + 2);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state_reg;
  logic             mode_1g_reg;
  logic             phase_reg;
  logic [3:0]       lo_nib_reg;
  logic [7:0]       s1_byte_reg;
  logic             s1_byte_v_reg;
  logic             s1_dv_reg;
  logic             s1_er_reg;
  logic             s1_odd_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [LEN_W-1:0] count_reg;
  logic [7:0]       hb_reg;
  logic             hb_v_reg;
  logic             first_reg;
  logic             frame_err_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             sop_reg;
  logic             eop_reg;
  logic             err_reg;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] good_cnt_reg;
  logic [CNT_W-1:0] bad_cnt_reg;

  assign rx.rx_data  = data_reg;
  assign rx.rx_valid = valid_reg;
  assign rx.rx_sop   = sop_reg;
  assign rx.rx_eop   = eop_reg;
  assign rx.rx_err   = err_reg;
  assign rx.rx_len   = len_reg;
  assign good_cnt    = good_cnt_reg;
  assign bad_cnt     = bad_cnt_reg;

  // Stage 1: decode dv/er and assemble bytes; a dv fall with half a byte pending flags an odd nibble.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_1g_reg   <= 1'b0;
      phase_reg     <= 1'b0;
      lo_nib_reg    <= 4'h0;
      s1_byte_reg   <= 8'h00;
      s1_byte_v_reg <= 1'b0;
      s1_dv_reg     <= 1'b0;
      s1_er_reg     <= 1'b0;
      s1_odd_reg    <= 1'b0;
    end else begin
      // Speed is only picked up between frames so a byte is never split across modes.
      if (state_reg == IDLE && !ddr_ctl_p) mode_1g_reg <= speed_1g;
      s1_dv_reg     <= ddr_ctl_p;
      s1_er_reg     <= ddr_ctl_p ^ ddr_ctl_n;
      s1_byte_v_reg <= 1'b0;
      s1_odd_reg    <= 1'b0;
      if (!ddr_ctl_p) begin
        s1_odd_reg <= phase_reg;
        phase_reg  <= 1'b0;
      end else if (mode_1g_reg) begin
        s1_byte_reg   <= {ddr_d_n, ddr_d_p};
        s1_byte_v_reg <= 1'b1;
      end else if (!phase_reg) begin
        lo_nib_reg <= ddr_d_p;
        phase_reg  <= 1'b1;
      end else begin
        s1_byte_reg   <= {ddr_d_p, lo_nib_reg};
        s1_byte_v_reg <= 1'b1;
        phase_reg     <= 1'b0;
      end
    end
  end

  // Framing FSM with a one-byte holdback so the last byte can carry eop when dv falls.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pre_cnt_reg   <= '0;
      count_reg     <= '0;
      hb_reg        <= 8'h00;
      hb_v_reg      <= 1'b0;
      first_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      sop_reg       <= 1'b0;
      eop_reg       <= 1'b0;
      err_reg       <= 1'b0;
      len_reg       <= '0;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
    end else begin
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
      err_reg   <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          pre_cnt_reg   <= '0;
          count_reg     <= '0;
          hb_v_reg      <= 1'b0;
          first_reg     <= 1'b1;
          frame_err_reg <= 1'b0;
          if (s1_byte_v_reg) begin
            if (s1_byte_reg == 8'h55) begin
              pre_cnt_reg <= PRE_W'(1);
              state_reg   <= PREAMBLE;
            end else if (s1_byte_reg == 8'hD5) begin
              state_reg <= DATA;
            end else begin
              bad_cnt_reg <= bad_cnt_reg + 1'b1;
              state_reg   <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (s1_dv_reg && s1_er_reg) frame_err_reg <= 1'b1;
          if (!s1_dv_reg) begin
            bad_cnt_reg <= bad_cnt_reg + 1'b1;
            state_reg   <= IDLE;
          end else if (s1_byte_v_reg) begin
            if (s1_byte_reg == 8'h55 && pre_cnt_reg < PRE_W'(MAX_PREAMBLE)) begin
              pre_cnt_reg <= pre_cnt_reg + 1'b1;
            end else if (s1_byte_reg == 8'hD5) begin
              state_reg <= DATA;
            end else begin
              bad_cnt_reg <= bad_cnt_reg + 1'b1;
              state_reg   <= DROP;
            end
          end
        end
        DATA: begin
          if (s1_dv_reg && s1_er_reg) frame_err_reg <= 1'b1;
          if (hb_v_reg && count_reg == LEN_W'(MAX_FRAME_LEN)) begin
            // Oversized frame: close it on the byte that hit the limit, discard the rest.
            data_reg    <= hb_reg;
            valid_reg   <= 1'b1;
            sop_reg     <= first_reg;
            eop_reg     <= 1'b1;
            err_reg     <= 1'b1;
            len_reg     <= count_reg;
            bad_cnt_reg <= bad_cnt_reg + 1'b1;
            hb_v_reg    <= 1'b0;
            state_reg   <= s1_dv_reg ? DROP : IDLE;
          end else if (!s1_dv_reg) begin
            if (hb_v_reg) begin
              data_reg  <= hb_reg;
              valid_reg <= 1'b1;
              sop_reg   <= first_reg;
              eop_reg   <= 1'b1;
              len_reg   <= count_reg;
              if (frame_err_reg || s1_odd_reg || count_reg < LEN_W'(MIN_FRAME_LEN)) begin
                err_reg     <= 1'b1;
                bad_cnt_reg <= bad_cnt_reg + 1'b1;
              end else begin
                good_cnt_reg <= good_cnt_reg + 1'b1;
              end
            end else begin
              // SFD with no payload behind it is counted as a bad frame.
              bad_cnt_reg <= bad_cnt_reg + 1'b1;
            end
            hb_v_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (s1_byte_v_reg) begin
            if (hb_v_reg) begin
              data_reg  <= hb_reg;
              valid_reg <= 1'b1;
              sop_reg   <= first_reg;
              first_reg <= 1'b0;
            end
            hb_reg    <= s1_byte_reg;
            hb_v_reg  <= 1'b1;
            if (count_reg != LEN_W'(MAX_FRAME_LEN)) count_reg <= count_reg + 1'b1;
          end
        end
        DROP: begin
          if (!s1_dv_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Self-checking bench for rgmii_rx_framer: directed scenarios plus random frames,
// each burst scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgmii_rx_framer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int MAX_PRE = 7;
  localparam int LEN_W   = 11;
  localparam int CNT_W   = 16;

  typedef struct {
    int len;
    bit err;
    bit lat;
    int sop_cyc;
    int eop_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             speed_1g = 1'b1;
  logic             ctl_p = 1'b0;
  logic             ctl_n = 1'b0;
  logic [3:0]       d_p = 4'h0;
  logic [3:0]       d_n = 4'h0;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         exp_good = 0;
  int         exp_bad = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_bytes[$];
  exp_t       exp_frames[$];
  logic [7:0] cur_q[$];
  bit         sop_first_ok;
  int         sop_cyc_seen;
  int         sop_extra = 0;

  rgmii_rx_framer_if #(.LEN_W(LEN_W)) rx_if();

  rgmii_rx_framer #(
    .MIN_FRAME_LEN(MIN_LEN), .MAX_FRAME_LEN(MAX_LEN), .MAX_PREAMBLE(MAX_PRE),
    .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .gmii_rx_clk(clk),
    .rst_n(rst_n),
    .speed_1g(speed_1g),
    .ddr_ctl_p(ctl_p),
    .ddr_ctl_n(ctl_n),
    .ddr_d_p(d_p),
    .ddr_d_n(d_n),
    .rx(rx_if),
    .good_cnt(good_cnt),
    .bad_cnt(bad_cnt)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Score one received frame against the oldest expected frame.
  task automatic frame_done();
    exp_t       e;
    int         mism;
    logic [7:0] eb;
    mism = 0;
    if (exp_frames.size() == 0) begin
      check("unexpected_frame", cur_q.size(), 0);
    end else begin
      e = exp_frames.pop_front();
      check("rx_len", rx_if.rx_len, e.len);
      check("rx_err", rx_if.rx_err, e.err);
      check("frame_bytes", cur_q.size(), e.len);
      for (int k = 0; k < e.len; k++) begin
        eb = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
        if (k >= cur_q.size() || cur_q[k] !== eb) mism++;
      end
      check("data_mismatches", mism, 0);
      check("sop_first", sop_first_ok, 1);
      check("sop_extra", sop_extra, 0);
      if (e.lat) begin
        check("sop_latency", sop_cyc_seen, e.sop_cyc);
        check("eop_latency", cyc, e.eop_cyc);
      end
    end
    cur_q.delete();
    sop_extra = 0;
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_q.delete();
      sop_extra = 0;
    end else if (rx_if.rx_valid) begin
      if (cur_q.size() == 0) begin
        sop_first_ok = rx_if.rx_sop;
        sop_cyc_seen = cyc;
      end else if (rx_if.rx_sop) begin
        sop_extra++;
      end
      cur_q.push_back(rx_if.rx_data);
      if (rx_if.rx_eop) frame_done();
    end
  end

  task automatic drive(input logic cp, input logic cn, input logic [3:0] dp, input logic [3:0] dn);
    ctl_p = cp;
    ctl_n = cn;
    d_p   = dp;
    d_n   = dn;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic set_speed(input logic m);
    idle(4);
    speed_1g = m;
    idle(4);
  endtask

  task automatic build_frame(input int npre, input logic [7:0] sfd, input int len, input bit incr);
    tx_q.delete();
    repeat (npre) tx_q.push_back(8'h55);
    tx_q.push_back(sfd);
    for (int k = 0; k < len; k++) tx_q.push_back(incr ? 8'(k) : 8'($urandom));
  endtask

  // Frame-level reference: parse the whole burst of line bytes into the expected result.
  task automatic model_burst(input bit m1g, input int er_idx, input bit odd, input int s);
    int   n;
    int   i;
    int   pay;
    bit   ok;
    exp_t e;
    n = tx_q.size();
    i = 0;
    while (i < n && tx_q[i] == 8'h55) i++;
    ok  = (i < n) && (tx_q[i] == 8'hD5) && (i <= MAX_PRE);
    pay = n - i - 1;
    if (!ok || pay <= 0) begin
      exp_bad++;
      return;
    end
    e.len = (pay >= MAX_LEN) ? MAX_LEN : pay;
    if (pay >= MAX_LEN) e.err = 1'b1;
    else e.err = (er_idx > i) || (pay < MIN_LEN) || (odd && !m1g);
    if (e.err) exp_bad++;
    else exp_good++;
    for (int k = 0; k < e.len; k++) exp_bytes.push_back(tx_q[i + 1 + k]);
    e.lat     = m1g;
    e.sop_cyc = s + i + 1 + 3;
    e.eop_cyc = (pay >= MAX_LEN) ? s + i + MAX_LEN + 3 : s + n + 2;
    exp_frames.push_back(e);
  endtask

  task automatic send_burst(input int er_idx, input bit odd, input int gap);
    bit   m1g;
    logic ce;
    m1g = speed_1g;
    model_burst(m1g, er_idx, odd, cyc);
    foreach (tx_q[j]) begin
      ce = (j == er_idx) ? 1'b0 : 1'b1;
      if (m1g) begin
        drive(1'b1, ce, tx_q[j][3:0], tx_q[j][7:4]);
      end else begin
        drive(1'b1, ce, tx_q[j][3:0], 4'($urandom));
        drive(1'b1, ce, tx_q[j][7:4], 4'($urandom));
      end
    end
    if (odd && !m1g) drive(1'b1, 1'b1, 4'($urandom), 4'($urandom));
    idle(gap);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_good_cnt"}, good_cnt, exp_good % 65536);
    check({tag, "_bad_cnt"}, bad_cnt, exp_bad % 65536);
  endtask

  initial begin
    int npre;
    int len;
    int er_idx;
    int gap;
    bit odd;
    logic [7:0] sfd;

    repeat (3) @(negedge clk);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_eop", rx_if.rx_eop, 0);
    check("rst_data", rx_if.rx_data, 0);
    check("rst_len", rx_if.rx_len, 0);
    check_counts("rst");
    rst_n = 1'b1;
    idle(4);

    // 1G: 7x55 + D5 + 00..3F
    build_frame(7, 8'hD5, 64, 1'b1);
    send_burst(-1, 1'b0, 4);
    check("t1_len", rx_if.rx_len, 64);
    check("t1_good", good_cnt, 1);

    // 10/100: same frame as nibbles
    set_speed(1'b0);
    build_frame(7, 8'hD5, 64, 1'b1);
    send_burst(-1, 1'b0, 4);
    check("t2_len", rx_if.rx_len, 64);
    check("t2_good", good_cnt, 2);

    // 1G: 60-byte frame with er on payload byte 10
    set_speed(1'b1);
    build_frame(7, 8'hD5, 60, 1'b1);
    send_burst(8 + 9, 1'b0, 4);
    check("t3_len", rx_if.rx_len, 60);
    check("t3_bad", bad_cnt, 1);
    check("t3_good", good_cnt, 2);

    // 1G: 2000-byte frame truncated, then a frame after a 1-cycle gap
    build_frame(7, 8'hD5, 2000, 1'b0);
    send_burst(-1, 1'b0, 1);
    build_frame(7, 8'hD5, 64, 1'b0);
    send_burst(-1, 1'b0, 4);
    check("t4_len", rx_if.rx_len, 64);
    check_counts("t4");

    // Broken preamble 55,55,AA,D5 -> dropped
    tx_q.delete();
    tx_q = '{8'h55, 8'h55, 8'hAA, 8'hD5};
    for (int k = 0; k < 20; k++) tx_q.push_back(8'($urandom));
    send_burst(-1, 1'b0, 4);
    check("t5_bad", bad_cnt, 3);

    // In-band status cycles (dv=0, er=1) are ignored
    repeat (10) drive(1'b0, 1'b1, 4'($urandom), 4'($urandom));
    check_counts("t6");

    // Reset in the middle of a frame, at payload byte 30
    build_frame(7, 8'hD5, 100, 1'b1);
    for (int j = 0; j < 8 + 30; j++) drive(1'b1, 1'b1, tx_q[j][3:0], tx_q[j][7:4]);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    check("t7_valid", rx_if.rx_valid, 0);
    check("t7_eop", rx_if.rx_eop, 0);
    check("t7_len", rx_if.rx_len, 0);
    check("t7_good", good_cnt, 0);
    check("t7_bad", bad_cnt, 0);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    exp_good = 0;
    exp_bad  = 0;
    rst_n = 1'b1;
    set_speed(1'b1);
    build_frame(7, 8'hD5, 64, 1'b0);
    send_burst(-1, 1'b0, 4);
    check("t7_good_after", good_cnt, 1);
    check_counts("t7");

    // Random frames in both modes
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 7) == 0) set_speed(~speed_1g);
      npre   = ($urandom_range(0, 9) == 0) ? 8 : $urandom_range(0, 7);
      sfd    = ($urandom_range(0, 9) == 0) ? 8'hA3 : 8'hD5;
      len    = $urandom_range(1, 100);
      build_frame(npre, sfd, len, 1'b0);
      er_idx = ($urandom_range(0, 4) == 0) ? npre + 1 + $urandom_range(0, len - 1) : -1;
      odd    = !speed_1g && ($urandom_range(0, 4) == 0);
      gap    = $urandom_range(1, 3);
      send_burst(er_idx, odd, gap);
      if (gap >= 2) check_counts("rand");
    end

    idle(10);
    check_counts("final");
    check("pending_frames", exp_frames.size(), 0);
    check("leftover_bytes", cur_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
